register_alias_table: RTL and testbench

REGISTER_ALIAS_TABLE -- requirements
Module: register_alias_table

---
 rtl/register_alias_table_if.sv | 20 ++
 rtl/register_alias_table.sv | 134 +++++++++++++
 tb/tb_register_alias_table.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/register_alias_table_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : register_alias_table_ifc
// Description : Register alias table view: per-register valid, value and tag.
// Revision    : 1.0
//------------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface register_alias_table_ifc;
    logic                   valid      [32];
    logic [`DATA_WIDTH-1:0] valueTable [32];
    logic [15:0]            tag        [32];

    modport out (output valid, valueTable, tag);
    modport in  (input  valid, valueTable, tag);
endinterface

`default_nettype wire

// File: rtl/register_alias_table.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : register_alias_table
// Description : Speculative register alias table with committed shadow copy,
//               16-bit tag allocator and flush recovery. Optional macro
//               RAT_WB_BYPASS_EN forwards same-cycle writebacks to the outputs.
// Revision    : 1.0
//------------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module register_alias_table (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rename_valid,
    input  logic [4:0]             rename_addr,
    output logic [15:0]            rename_tag,
    input  logic                   wb_valid,
    input  logic [15:0]            wb_tag,
    input  logic [`DATA_WIDTH-1:0] wb_data,
    input  logic                   commit_valid,
    input  logic [4:0]             commit_addr,
    input  logic [`DATA_WIDTH-1:0] commit_data,
    input  logic                   flush,
    register_alias_table_ifc.out   rat
);

    localparam int c_NUM_REGS = 32;
    localparam int c_DW       = `DATA_WIDTH;

    logic              spec_valid_q [c_NUM_REGS];
    logic              spec_valid_d [c_NUM_REGS];
    logic [c_DW-1:0]   spec_value_q [c_NUM_REGS];
    logic [c_DW-1:0]   spec_value_d [c_NUM_REGS];
    logic [15:0]       spec_tag_q   [c_NUM_REGS];
    logic [15:0]       spec_tag_d   [c_NUM_REGS];
    logic [c_DW-1:0]   arch_value_q [c_NUM_REGS];
    logic [c_DW-1:0]   arch_value_d [c_NUM_REGS];
    logic [15:0]       tag_ctr_q;
    logic [15:0]       tag_ctr_d;

    logic [c_NUM_REGS-1:0] w_wb_hit;
    logic                  w_rename_en;

    assign rename_tag  = tag_ctr_q;
    assign w_rename_en = rename_valid && (rename_addr != 5'd0);

    always_comb begin
        for (int r = 0; r < c_NUM_REGS; r++) begin
            w_wb_hit[r] = wb_valid && (wb_tag != 16'h0000) &&
                          !spec_valid_q[r] && (spec_tag_q[r] == wb_tag);
        end
    end

    always_comb begin
        tag_ctr_d = tag_ctr_q;
        for (int r = 0; r < c_NUM_REGS; r++) begin
            spec_valid_d[r] = spec_valid_q[r];
            spec_value_d[r] = spec_value_q[r];
            spec_tag_d[r]   = spec_tag_q[r];
            arch_value_d[r] = arch_value_q[r];
        end

        if (commit_valid && (commit_addr != 5'd0)) begin
            arch_value_d[commit_addr] = commit_data;
        end

        if (flush) begin
            // arch_value_d already carries a same-cycle commit, giving the bypass.
            for (int r = 0; r < c_NUM_REGS; r++) begin
                spec_valid_d[r] = 1'b1;
                spec_tag_d[r]   = 16'h0000;
                spec_value_d[r] = arch_value_d[r];
            end
        end else begin
            for (int r = 0; r < c_NUM_REGS; r++) begin
                if (w_wb_hit[r]) begin
                    spec_valid_d[r] = 1'b1;
                    spec_value_d[r] = wb_data;
                end
            end
            // Applied after writeback so a colliding rename wins.
            if (w_rename_en) begin
                spec_valid_d[rename_addr] = 1'b0;
                spec_tag_d[rename_addr]   = tag_ctr_q;
                tag_ctr_d = (tag_ctr_q == 16'hFFFF) ? 16'h0001 : tag_ctr_q + 16'h0001;
            end
        end

        spec_valid_d[0] = 1'b1;
        spec_value_d[0] = '0;
        spec_tag_d[0]   = 16'h0000;
        arch_value_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < c_NUM_REGS; r++) begin
                spec_valid_q[r] <= 1'b1;
                spec_value_q[r] <= '0;
                spec_tag_q[r]   <= 16'h0000;
                arch_value_q[r] <= '0;
            end
            tag_ctr_q <= 16'h0001;
        end else begin
            for (int r = 0; r < c_NUM_REGS; r++) begin
                spec_valid_q[r] <= spec_valid_d[r];
                spec_value_q[r] <= spec_value_d[r];
                spec_tag_q[r]   <= spec_tag_d[r];
                arch_value_q[r] <= arch_value_d[r];
            end
            tag_ctr_q <= tag_ctr_d;
        end
    end

    always_comb begin
        for (int r = 0; r < c_NUM_REGS; r++) begin
            rat.valid[r]      = spec_valid_q[r];
            rat.valueTable[r] = spec_value_q[r];
            rat.tag[r]        = spec_tag_q[r];
`ifdef RAT_WB_BYPASS_EN
            if (w_wb_hit[r] && !flush && !(w_rename_en && (rename_addr == 5'(r)))) begin
                rat.valid[r]      = 1'b1;
                rat.valueTable[r] = wb_data;
            end
`else
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_register_alias_table.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_register_alias_table
// Description : Directed bench for register_alias_table with a reference model.
// Revision    : 1.0
//------------------------------------------------------------------------------
module tb_register_alias_table;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rename_valid = 1'b0;
    logic [4:0]  rename_addr = 5'd0;
    logic [15:0] rename_tag;
    logic        wb_valid = 1'b0;
    logic [15:0] wb_tag = 16'h0;
    logic [31:0] wb_data = 32'h0;
    logic        commit_valid = 1'b0;
    logic [4:0]  commit_addr = 5'd0;
    logic [31:0] commit_data = 32'h0;
    logic        flush = 1'b0;

    register_alias_table_ifc rat_if ();

    register_alias_table dut (
        .clk          (clk),
        .rst          (rst),
        .rename_valid (rename_valid),
        .rename_addr  (rename_addr),
        .rename_tag   (rename_tag),
        .wb_valid     (wb_valid),
        .wb_tag       (wb_tag),
        .wb_data      (wb_data),
        .commit_valid (commit_valid),
        .commit_addr  (commit_addr),
        .commit_data  (commit_data),
        .flush        (flush),
        .rat          (rat_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    // Reference model: plain arrays updated by the rules at each rising edge.
    bit          m_valid [32];
    logic [31:0] m_value [32];
    logic [15:0] m_tag   [32];
    logic [31:0] m_arch  [32];
    int          m_ctr = 1;

    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_valid[r] = 1'b1; m_value[r] = 32'h0; m_tag[r] = 16'h0; m_arch[r] = 32'h0;
            end
            m_ctr = 1;
        end else begin
            if (flush) begin
                for (int r = 0; r < 32; r++) begin
                    m_valid[r] = 1'b1;
                    m_tag[r]   = 16'h0;
                    m_value[r] = (commit_valid && r != 0 && int'(commit_addr) == r) ? commit_data : m_arch[r];
                end
            end else begin
                if (wb_valid && wb_tag != 16'h0)
                    for (int r = 0; r < 32; r++)
                        if (!m_valid[r] && m_tag[r] == wb_tag) begin
                            m_valid[r] = 1'b1; m_value[r] = wb_data;
                        end
                if (rename_valid && rename_addr != 5'd0) begin
                    m_valid[rename_addr] = 1'b0;
                    m_tag[rename_addr]   = 16'(m_ctr);
                    m_ctr = m_ctr % 65535 + 1;
                end
            end
            if (commit_valid && commit_addr != 5'd0) m_arch[commit_addr] = commit_data;
        end
    end

    always @(negedge clk) begin : compare
        int          bad_r;
        bit          ev;
        logic [31:0] eval;
        logic [15:0] et;
        bit          bv;
        logic [31:0] bval;
        logic [15:0] bt;
        if (checking) begin
            n_cmp++;
            if (rename_tag !== 16'(m_ctr)) begin
                n_bad++;
                $display("FAIL rename_tag @%0t: got %h want %h", $time, rename_tag, 16'(m_ctr));
            end
            bad_r = -1; bv = 1'b0; bval = 32'h0; bt = 16'h0;
            for (int r = 0; r < 32; r++) begin
                ev = m_valid[r]; eval = m_value[r]; et = m_tag[r];
`ifdef RAT_WB_BYPASS_EN
                if (wb_valid && wb_tag != 16'h0 && !ev && et == wb_tag && !flush &&
                    !(rename_valid && rename_addr != 5'd0 && int'(rename_addr) == r)) begin
                    ev = 1'b1; eval = wb_data;
                end
`else
`endif
                if (bad_r < 0 && (rat_if.valid[r] !== ev || rat_if.valueTable[r] !== eval ||
                                  rat_if.tag[r] !== et)) begin
                    bad_r = r; bv = ev; bval = eval; bt = et;
                end
            end
            n_cmp++;
            if (bad_r >= 0) begin
                n_bad++;
                $display("FAIL table[%0d] @%0t: got v=%0b val=%h tag=%h want v=%0b val=%h tag=%h",
                         bad_r, $time, rat_if.valid[bad_r], rat_if.valueTable[bad_r],
                         rat_if.tag[bad_r], bv, bval, bt);
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    task automatic set_in(input bit rv, input logic [4:0] ra, input bit wv, input logic [15:0] wt,
                          input logic [31:0] wd, input bit cv, input logic [4:0] ca,
                          input logic [31:0] cd, input bit fl);
        rename_valid = rv; rename_addr = ra;
        wb_valid = wv; wb_tag = wt; wb_data = wd;
        commit_valid = cv; commit_addr = ca; commit_data = cd;
        flush = fl;
    endtask

    task automatic step;
        @(posedge clk);
        #2;
        rename_valid = 1'b0; wb_valid = 1'b0; commit_valid = 1'b0; flush = 1'b0; rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        step();
        checking = 1'b1;
        lit("reset_rename_tag", 32'(rename_tag), 32'h1);
        lit("reset_valid9", 32'(rat_if.valid[9]), 32'h1);
        lit("reset_tag9", 32'(rat_if.tag[9]), 32'h0);
        lit("reset_value9", rat_if.valueTable[9], 32'h0);

        set_in(1, 5'd5, 0, 16'h0, 32'h0, 0, 5'd0, 32'h0, 0);
        #1 lit("rename5_tag_now", 32'(rename_tag), 32'h1);
        step();
        lit("rename5_valid", 32'(rat_if.valid[5]), 32'h0);
        lit("rename5_tag", 32'(rat_if.tag[5]), 32'h1);
        lit("ctr_after_rename5", 32'(rename_tag), 32'h2);

        set_in(0, 5'd0, 1, 16'h0001, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0);
`ifdef RAT_WB_BYPASS_EN
        #1 lit("wb5_bypass_valid", 32'(rat_if.valid[5]), 32'h1);
        lit("wb5_bypass_value", rat_if.valueTable[5], 32'hDEADBEEF);
`else
        #1 lit("wb5_not_yet_visible", 32'(rat_if.valid[5]), 32'h0);
`endif
        step();
        lit("wb5_valid", 32'(rat_if.valid[5]), 32'h1);
        lit("wb5_value", rat_if.valueTable[5], 32'hDEADBEEF);

        set_in(1, 5'd7, 0, 16'h0, 32'h0, 0, 5'd0, 32'h0, 0); step();
        set_in(1, 5'd7, 1, 16'h0002, 32'h77, 0, 5'd0, 32'h0, 0); step();
        lit("collide7_valid", 32'(rat_if.valid[7]), 32'h0);
        lit("collide7_tag", 32'(rat_if.tag[7]), 32'h3);

        set_in(0, 5'd0, 1, 16'h0003, 32'h33, 0, 5'd0, 32'h0, 0); step();
        lit("wb7_value", rat_if.valueTable[7], 32'h33);
        set_in(0, 5'd0, 1, 16'h0000, 32'hFF, 0, 5'd0, 32'h0, 0); step();
        set_in(0, 5'd0, 1, 16'h0055, 32'h55, 0, 5'd0, 32'h0, 0); step();

        set_in(1, 5'd3, 0, 16'h0, 32'h0, 0, 5'd0, 32'h0, 0); step();
        set_in(1, 5'd9, 1, 16'h0004, 32'h99, 1, 5'd3, 32'h12, 1); step();
        lit("flush3_valid", 32'(rat_if.valid[3]), 32'h1);
        lit("flush3_value", rat_if.valueTable[3], 32'h12);
        lit("flush3_tag", 32'(rat_if.tag[3]), 32'h0);
        lit("flush_ctr_hold", 32'(rename_tag), 32'h5);
        lit("flush5_value", rat_if.valueTable[5], 32'h0);
        lit("flush9_valid", 32'(rat_if.valid[9]), 32'h1);

        set_in(0, 5'd0, 0, 16'h0, 32'h0, 1, 5'd5, 32'hAAAA, 0); step();
        set_in(0, 5'd0, 0, 16'h0, 32'h0, 1, 5'd0, 32'h1, 0); step();
        set_in(0, 5'd0, 0, 16'h0, 32'h0, 0, 5'd0, 32'h0, 1); step();
        lit("commit5_after_flush", rat_if.valueTable[5], 32'hAAAA);
        lit("commit0_ignored", rat_if.valueTable[0], 32'h0);

        set_in(1, 5'd0, 0, 16'h0, 32'h0, 0, 5'd0, 32'h0, 0);
        #1 lit("rename0_tag_now", 32'(rename_tag), 32'h5);
        step();
        lit("rename0_ctr_hold", 32'(rename_tag), 32'h5);
        lit("rename0_valid", 32'(rat_if.valid[0]), 32'h1);

        set_in(1, 5'd6, 0, 16'h0, 32'h0, 1, 5'd6, 32'h66, 1);
        rst = 1'b1;
        step();
        lit("rst_ctr", 32'(rename_tag), 32'h1);
        lit("rst_valid6", 32'(rat_if.valid[6]), 32'h1);
        set_in(0, 5'd0, 0, 16'h0, 32'h0, 0, 5'd0, 32'h0, 1); step();
        lit("rst_arch6", rat_if.valueTable[6], 32'h0);
        lit("rst_arch5", rat_if.valueTable[5], 32'h0);

        for (int i = 0; i < 65534; i++) begin
            set_in(1, 5'd1, 0, 16'h0, 32'h0, 0, 5'd0, 32'h0, 0);
            step();
        end
        lit("ctr_at_ffff", 32'(rename_tag), 32'hFFFF);
        set_in(1, 5'd2, 0, 16'h0, 32'h0, 0, 5'd0, 32'h0, 0); step();
        lit("wrap_tag2", 32'(rat_if.tag[2]), 32'hFFFF);
        set_in(1, 5'd4, 0, 16'h0, 32'h0, 0, 5'd0, 32'h0, 0); step();
        lit("wrap_tag4", 32'(rat_if.tag[4]), 32'h1);
        lit("wrap_ctr", 32'(rename_tag), 32'h2);
        set_in(0, 5'd0, 1, 16'hFFFF, 32'hF0F0, 0, 5'd0, 32'h0, 0); step();
        lit("wb_ffff_value2", rat_if.valueTable[2], 32'hF0F0);
        lit("wb_ffff_r1_pending", 32'(rat_if.valid[1]), 32'h0);
        set_in(0, 5'd0, 1, 16'h0001, 32'h4444, 0, 5'd0, 32'h0, 0); step();
        lit("wb_1_value4", rat_if.valueTable[4], 32'h4444);
        @(negedge clk);
        checking = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
